score_streamer: RTL and testbench
=================================

SCORE_STREAMER -- requirements
Module: score_streamer

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 32, the width of one score and one index.
REQ-002 The block SHALL have parameter CELL_AMOUNT, default 4, the number of scores per vector; legal values are 2 or more.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all logic updates on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have port vector_in, input, CELL_AMOUNT*DATA_WIDTH bits: the score vector; element i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-006 The block SHALL have port vector_valid, input, 1 bit: vector_in holds a vector.
REQ-007 The block SHALL have port vector_ready, output, 1 bit: the block can accept a vector this cycle.
REQ-008 The block SHALL have port out_index, output, DATA_WIDTH bits: element index, which feeds input_index of the argmax stage.
REQ-009 The block SHALL have port out_value, output, DATA_WIDTH bits: element score, which feeds input_value.
REQ-010 The block SHALL have port out_enable, output, 1 bit: out_index and out_value are valid; feeds input_enable.
REQ-011 The block SHALL have port busy, output, 1 bit: a vector is streaming or a vector is pending.

Function
REQ-012 The block SHALL hold two vector slots: active (streaming) and pending (next vector).
REQ-013 The block SHALL implement a state machine with states IDLE and STREAM, plus an internal element counter of width $clog2(CELL_AMOUNT).
REQ-014 A handshake SHALL complete on a rising edge where vector_valid=1 and vector_ready=1; with no handshake, vector_in SHALL be ignored.
REQ-015 vector_ready SHALL be combinational and equal to !reset && !pending_full.
REQ-016 In IDLE, a handshake SHALL capture the vector into active and, on the same edge, register out_index=0, out_value=element 0 and out_enable=1, and move to STREAM with counter=1.
REQ-017 In STREAM with counter=c, each edge SHALL register out_index=c, out_value=active element c and out_enable=1, then increment c.
REQ-018 In STREAM, a handshake SHALL capture the vector into pending.
REQ-019 On the edge that emits index CELL_AMOUNT-1:
  - if pending is full, the pending vector SHALL move to active, pending SHALL clear, and the next edge SHALL emit index 0 of the new vector (back-to-back, no gap);
  - else, if a handshake occurs on that same edge, the incoming vector SHALL go directly to active and stream back-to-back;
  - else, the next edge SHALL go to IDLE.
REQ-020 On any edge where no element is emitted, including entry to IDLE, the block SHALL register out_enable=0, out_index=0 and out_value=0.
REQ-021 Every vector SHALL stream exactly CELL_AMOUNT elements with indices 0..CELL_AMOUNT-1 in ascending order, on consecutive cycles.
REQ-022 The streamed out_value SHALL be bit-exact with the captured element, with no arithmetic applied.
REQ-023 busy SHALL be 1 when the state is STREAM or pending is full, else 0.
REQ-024 Changes on vector_in after a handshake SHALL NOT affect the captured data.

Reset
REQ-025 While reset=1 at a rising edge, the block SHALL set state=IDLE, counter=0, pending empty, out_index=0, out_value=0, out_enable=0 and busy=0.
REQ-026 A reset asserted mid-vector SHALL discard both active and pending data, with no further elements emitted.
REQ-027 vector_ready SHALL be 0 during reset and 1 on the first cycle after reset deasserts.
REQ-028 The block SHALL accept a handshake on the first edge after reset deasserts.

Verification (DATA_WIDTH=32, CELL_AMOUNT=4)
REQ-029 Single vector: send {10,40,20,30} in IDLE -> over 4 consecutive cycles (index,value) = (0,10),(1,40),(2,20),(3,30), then out_enable=0 and busy=0.
REQ-030 Back-to-back: send vector A = {1,2,3,4}, then send vector B = {5,6,7,8} during A's index 1 -> out_enable stays high for 8 cycles, indices 0,1,2,3,0,1,2,3, values 1..8.
REQ-031 Backpressure: send A, then B (pending), then hold C valid -> vector_ready=0 until B moves to active; C is accepted after that and streams after B with no data lost or duplicated.
REQ-032 Simultaneous: handshake coincides with the index-3 edge and pending is empty -> the new vector streams starting at index 0 on the next cycle, with no gap.
REQ-033 Reset mid-stream: assert reset at index 1 with a vector pending -> out_enable=0 on the next cycle, the pending vector is never emitted, and busy=0.
REQ-034 Downstream check: chain this block to the argmax stage, send {7,9,9,2} -> the argmax result index is 2 (ties resolve to the later index) and the valid bit is 1.

Source files
------------

// File: rtl/score_streamer.sv
// rtl/score_streamer.sv - streams a score vector one element per cycle
// into the argmax stage, with one pending slot for back-to-back vectors.
module score_streamer #(
    parameter int DATA_WIDTH  = 32,
    parameter int CELL_AMOUNT = 4
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic [CELL_AMOUNT*DATA_WIDTH-1:0] vector_in,
    input  logic                              vector_valid,
    output logic                              vector_ready,
    output logic [DATA_WIDTH-1:0]             out_index,
    output logic [DATA_WIDTH-1:0]             out_value,
    output logic                              out_enable,
    output logic                              busy
);

    localparam int CW = $clog2(CELL_AMOUNT);
    localparam logic [CW-1:0] LAST = CW'(CELL_AMOUNT - 1);

    typedef enum logic {IDLE, STREAM} state_t;

    state_t                            state;
    logic [CW-1:0]                     cnt;
    logic [DATA_WIDTH-1:0]             active [CELL_AMOUNT];
    logic [CELL_AMOUNT*DATA_WIDTH-1:0] pending;
    logic                              pending_full;
    logic                              take;

    assign vector_ready = !reset && !pending_full;
    assign take         = vector_valid && vector_ready;
    assign busy         = (state == STREAM) || pending_full;

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            cnt          <= '0;
            pending_full <= 1'b0;
            out_index    <= '0;
            out_value    <= '0;
            out_enable   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (take) begin
                        for (int i = 0; i < CELL_AMOUNT; i++)
                            active[i] <= vector_in[i*DATA_WIDTH +: DATA_WIDTH];
                        out_index  <= '0;
                        out_value  <= vector_in[0 +: DATA_WIDTH];
                        out_enable <= 1'b1;
                        cnt        <= CW'(1);
                        state      <= STREAM;
                    end else begin
                        out_index  <= '0;
                        out_value  <= '0;
                        out_enable <= 1'b0;
                    end
                end
                STREAM: begin
                    out_index  <= DATA_WIDTH'(cnt);
                    out_value  <= active[cnt];
                    out_enable <= 1'b1;
                    if (cnt == LAST) begin
                        // Last element: refill from pending, else from a same-edge handshake.
                        cnt <= '0;
                        if (pending_full) begin
                            for (int i = 0; i < CELL_AMOUNT; i++)
                                active[i] <= pending[i*DATA_WIDTH +: DATA_WIDTH];
                            pending_full <= 1'b0;
                        end else if (take) begin
                            for (int i = 0; i < CELL_AMOUNT; i++)
                                active[i] <= vector_in[i*DATA_WIDTH +: DATA_WIDTH];
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        cnt <= cnt + CW'(1);
                        if (take) begin
                            pending      <= vector_in;
                            pending_full <= 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_score_streamer.sv
// tb/tb_score_streamer.sv - directed self-checking bench for score_streamer
// with a behavioural argmax stage on the output stream.
module tb_score_streamer;

    logic         clk = 1'b0;
    logic         reset;
    logic [127:0] vector_in;
    logic         vector_valid;
    logic         vector_ready;
    logic [31:0]  out_index;
    logic [31:0]  out_value;
    logic         out_enable;
    logic         busy;

    int n_cmp = 0;
    int n_bad = 0;

    logic [31:0] am_idx;
    logic [31:0] am_val;
    logic        am_valid;

    score_streamer #(.DATA_WIDTH(32), .CELL_AMOUNT(4)) dut (
        .clk(clk),
        .reset(reset),
        .vector_in(vector_in),
        .vector_valid(vector_valid),
        .vector_ready(vector_ready),
        .out_index(out_index),
        .out_value(out_value),
        .out_enable(out_enable),
        .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [127:0] pack(input logic [31:0] e0, e1, e2, e3);
        return {e3, e2, e1, e0};
    endfunction

    task automatic expect_elem(input string tag, input int i, input int v);
        @(negedge clk);
        check($sformatf("%s_en%0d", tag, i), {31'd0, out_enable}, 32'd1);
        check($sformatf("%s_idx%0d", tag, i), out_index, i);
        check($sformatf("%s_val%0d", tag, i), out_value, v);
    endtask

    task automatic expect_idle(input string tag);
        @(negedge clk);
        check({tag, "_en"}, {31'd0, out_enable}, 32'd0);
        check({tag, "_idx"}, out_index, 32'd0);
        check({tag, "_val"}, out_value, 32'd0);
        check({tag, "_busy"}, {31'd0, busy}, 32'd0);
    endtask

    initial begin
        reset        = 1'b1;
        vector_valid = 1'b0;
        vector_in    = '0;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_en", {31'd0, out_enable}, 32'd0);
        check("rst_idx", out_index, 32'd0);
        check("rst_val", out_value, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_ready", {31'd0, vector_ready}, 32'd0);
        reset = 1'b0;
        #1;
        check("post_rst_ready", {31'd0, vector_ready}, 32'd1);

        // Single vector; input scrambled after handshake must not matter
        vector_in = pack(10, 40, 20, 30); vector_valid = 1'b1;
        expect_elem("single", 0, 10);
        vector_valid = 1'b0; vector_in = pack(99, 99, 99, 99);
        check("single_busy", {31'd0, busy}, 32'd1);
        expect_elem("single", 1, 40);
        expect_elem("single", 2, 20);
        expect_elem("single", 3, 30);
        expect_idle("single_end");

        // Back-to-back: B handshakes on A's index-1 edge
        vector_in = pack(1, 2, 3, 4); vector_valid = 1'b1;
        expect_elem("b2b", 0, 1);
        vector_in = pack(5, 6, 7, 8);
        expect_elem("b2b", 1, 2);
        vector_valid = 1'b0;
        check("b2b_busy_pend", {31'd0, busy}, 32'd1);
        expect_elem("b2b", 2, 3);
        expect_elem("b2b", 3, 4);
        for (int i = 0; i < 4; i++) expect_elem("b2b_b", i, 5 + i);
        expect_idle("b2b_end");

        // Backpressure: C held valid while B is pending
        vector_in = pack(1, 2, 3, 4); vector_valid = 1'b1;
        expect_elem("bp_a", 0, 1);
        vector_in = pack(5, 6, 7, 8);
        expect_elem("bp_a", 1, 2);
        vector_in = pack(9, 10, 11, 12);
        check("bp_ready_lo1", {31'd0, vector_ready}, 32'd0);
        expect_elem("bp_a", 2, 3);
        check("bp_ready_lo2", {31'd0, vector_ready}, 32'd0);
        expect_elem("bp_a", 3, 4);
        check("bp_ready_hi", {31'd0, vector_ready}, 32'd1);
        expect_elem("bp_b", 0, 5);
        vector_valid = 1'b0;
        check("bp_ready_c_pend", {31'd0, vector_ready}, 32'd0);
        for (int i = 1; i < 4; i++) expect_elem("bp_b", i, 5 + i);
        for (int i = 0; i < 4; i++) expect_elem("bp_c", i, 9 + i);
        expect_idle("bp_end");

        // Handshake coincides with the index-3 edge, pending empty
        vector_in = pack(21, 22, 23, 24); vector_valid = 1'b1;
        expect_elem("sim_a", 0, 21);
        vector_valid = 1'b0;
        expect_elem("sim_a", 1, 22);
        expect_elem("sim_a", 2, 23);
        vector_in = pack(31, 32, 33, 34); vector_valid = 1'b1;
        check("sim_ready", {31'd0, vector_ready}, 32'd1);
        expect_elem("sim_a", 3, 24);
        vector_valid = 1'b0;
        for (int i = 0; i < 4; i++) expect_elem("sim_b", i, 31 + i);
        expect_idle("sim_end");

        // Reset at index 1 with a vector pending
        vector_in = pack(41, 42, 43, 44); vector_valid = 1'b1;
        expect_elem("mid_a", 0, 41);
        vector_in = pack(51, 52, 53, 54);
        expect_elem("mid_a", 1, 42);
        vector_valid = 1'b0;
        reset = 1'b1;
        expect_idle("mid_rst");
        check("mid_rst_ready", {31'd0, vector_ready}, 32'd0);
        reset = 1'b0;
        for (int i = 0; i < 5; i++) expect_idle($sformatf("mid_quiet%0d", i));

        // Handshake on first edge after reset, downstream argmax with a tie
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        vector_in = pack(7, 9, 9, 2); vector_valid = 1'b1;
        am_idx = '0; am_val = '0; am_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            expect_elem("am", i, (i == 0) ? 7 : (i == 3) ? 2 : 9);
            vector_valid = 1'b0;
            if (out_enable && (out_index == 0 || out_value >= am_val)) begin
                am_val = out_value;
                am_idx = out_index;
            end
            if (out_enable && out_index == 3) am_valid = 1'b1;
        end
        check("argmax_idx", am_idx, 32'd2);
        check("argmax_valid", {31'd0, am_valid}, 32'd1);
        expect_idle("am_end");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
